// File: rtl/adpcm_stream_ctrl.sv
// adpcm_stream_ctrl: PDM clock/strobe sequencer, warm-up gate and
// nibble packer with a small byte FIFO behind a valid/ready port.
module adpcm_stream_ctrl #(
  parameter int PDM_DIV    = 4,
  parameter int DECIM      = 64,
  parameter int WARMUP     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       pdm_clk,
  output logic       cmp_enable,
  output logic       cmp_pdm_stb,
  output logic       cmp_pcm_stb,
  input  logic       cmp_valid,
  input  logic [3:0] cmp_code,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int DW = (PDM_DIV > 2) ? $clog2(PDM_DIV) : 1;
  localparam int CW = $clog2(DECIM);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST  = DW'(PDM_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(PDM_DIV / 2);
  localparam logic [CW-1:0] PCM_LAST  = CW'(DECIM - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] pcm_cnt;
  logic [WW-1:0] warm_cnt;
  logic          phase;
  logic [3:0]    nibble;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [AW:0]   count, left;

  logic          capture, cap_nxt;
  logic          push, push_ok, pop;
  logic [7:0]    push_data, head_nxt;

  assign capture     = (state == WARM) || (state == RUN);
  assign cap_nxt     = capture &&
                       ((state_nxt == WARM) || (state_nxt == RUN));
  assign pdm_clk     = capture && (div_cnt >= DIV_HALF);
  assign cmp_pdm_stb = capture && (div_cnt == DIV_LAST);
  assign cmp_pcm_stb = cmp_pdm_stb && (pcm_cnt == PCM_LAST);
  assign cmp_enable  = capture;
  assign busy        = (state != IDLE);
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign push_ok     = push && ((count != FULL_CNT) || pop);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = {cmp_code, nibble};
    unique case (state)
      IDLE: if (run) state_nxt = WARM;
      WARM: begin
        if (!run)
          state_nxt = IDLE;
        else if (cmp_valid && warm_cnt == WARM_LAST)
          state_nxt = RUN;
      end
      RUN: begin
        push = cmp_valid && phase;
        if (!run) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (phase) begin
          push      = 1'b1;
          push_data = {4'h0, nibble};
        end else if (count == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head register tracks the slot that will be at the front next cycle.
  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    left       = count - (AW+1)'(pop);
    head_nxt   = out_data;
    if (left != '0)
      head_nxt = mem[rd_ptr_nxt];
    else if (push_ok)
      head_nxt = push_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      pcm_cnt  <= '0;
      warm_cnt <= '0;
      phase    <= 1'b0;
      nibble   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;

      if (!cap_nxt)
        div_cnt <= '0;
      else
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);

      if (!cap_nxt)
        pcm_cnt <= '0;
      else if (cmp_pdm_stb)
        pcm_cnt <= (pcm_cnt == PCM_LAST) ? '0 : pcm_cnt + CW'(1);

      if (state == IDLE)
        warm_cnt <= '0;
      else if (state == WARM && cmp_valid)
        warm_cnt <= warm_cnt + WW'(1);

      if (state == IDLE && run) begin
        phase    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (push && !push_ok) overflow <= 1'b1;
        if (state == RUN && cmp_valid) begin
          phase <= ~phase;
          if (!phase) nibble <= cmp_code;
        end else if (state == DRAIN) begin
          phase <= 1'b0;
        end
      end

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      out_data <= head_nxt;
    end
  end

endmodule

// File: doc/adpcm_stream_ctrl.md
# adpcm_stream_ctrl

Sequencer and output packer for the CIC/ADPCM compressor datapath. It generates the PDM microphone clock and the compressor's bit-rate and sample-rate strobes, and gates the compressor enable through a start-up warm-up. It packs the 4-bit ADPCM codes into bytes and buffers them in a small FIFO behind a valid/ready output port. It sits between the top-level pins and the compressor instance and replaces direct pin drive of the compressor clocks and enable.

## Interface
- PDM_DIV, 4: clk cycles per PDM clock period; even, ≥2.
- DECIM, 64: PDM bits per PCM sample; ≥2.
- WARMUP, 8: number of initial ADPCM codes discarded while the CIC settles; ≥1.
- FIFO_DEPTH, 4: output byte FIFO depth; power of two, ≥2.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level input; 1 requests capture, 0 requests stop.
- pdm_clk  out  1  PDM microphone clock; low whenever the block is not capturing.
- cmp_enable  out  1  compressor block enable.
- cmp_pdm_stb  out  1  one-cycle strobe; compressor samples one PDM bit.
- cmp_pcm_stb  out  1  one-cycle strobe; compressor produces one sample (slow rate).
- cmp_valid  in  1  compressor code valid, one cycle per code.
- cmp_code  in  4  ADPCM code.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  state ≠ IDLE.
- overflow  out  1  sticky flag; a byte was dropped because the FIFO was full.

## Operation
- The FSM has four states: IDLE, WARM, RUN and DRAIN. Reset enters IDLE.
- IDLE:
  - Divider and counters are held at 0.
  - pdm_clk = 0, cmp_enable = 0, no strobes.
  - run = 1 → WARM. On this transition overflow is cleared.
- WARM:
  - cmp_enable = 1.
  - Counters are live. Each cmp_valid increments warm_cnt; the code is discarded.
  - The cmp_valid that makes warm_cnt reach WARMUP → RUN. That code is also discarded.
  - run = 0 → IDLE.
- RUN:
  - cmp_enable = 1; every cmp_valid code is packed.
  - run = 0 → DRAIN. Strobes and cmp_enable stop the next cycle; pdm_clk is forced to 0.
- DRAIN:
  - If a nibble is pending, push {4'h0, nibble} once.
  - When the FIFO is empty and nothing is pending → IDLE.
  - run = 1 during DRAIN is ignored until IDLE is reached.
- Divider:
  - div_cnt counts 0..PDM_DIV-1 and wraps.
  - pdm_clk = 1 when div_cnt ≥ PDM_DIV/2.
  - cmp_pdm_stb = 1 when div_cnt = PDM_DIV-1.
- Decimation:
  - pcm_cnt counts cmp_pdm_stb pulses 0..DECIM-1.
  - cmp_pcm_stb = cmp_pdm_stb AND pcm_cnt = DECIM-1. Both strobes are coincident in that cycle.
- Packing:
  - A nibble-phase bit selects the byte half. The first accepted code is held as the low nibble.
  - The second code pushes {code2, code1}.
  - The phase is cleared on entering WARM.
- FIFO:
  - Pop when out_valid AND out_ready.
  - A push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Push and pop in the same cycle leave the count unchanged.
- Reset mid-operation has the same effect at any time:
  - FIFO emptied, pending nibble discarded, state → IDLE.
  - All outputs 0 the cycle after rst is sampled.

## Timing
- Reset value of every output is 0.
- First cmp_pdm_stb occurs PDM_DIV cycles after the cycle that enters WARM (div_cnt starts at 0).
- Strobe period:
  - cmp_pdm_stb every PDM_DIV cycles.
  - cmp_pcm_stb every PDM_DIV·DECIM cycles.
- Push latency: a code sampled on cmp_valid in cycle N that completes a byte makes out_valid = 1 in cycle N+1, provided the FIFO was empty.
- out_data is registered from FIFO storage and is stable while out_valid = 1 and out_ready = 0.
- busy drops in the cycle after the DRAIN → IDLE transition.

## Test plan
- **Strobes.** PDM_DIV=4, DECIM=8, run=1 held. Required:
  - pdm_clk pattern 0,0,1,1 repeating.
  - cmp_pdm_stb every 4 cycles.
  - cmp_pcm_stb every 32 cycles, coincident with cmp_pdm_stb.
- **Warm-up and packing.** WARMUP=2; codes 0xF, 0xE, 0x3, 0xA. Required: 0xF and 0xE discarded; single byte 0xA3 presented, out_valid rising one cycle after the 0xA code.
- **Backpressure and overflow.** FIFO_DEPTH=4, out_ready=0, 10 codes sent after warm-up. Required:
  - 4 bytes held; the 5th byte is dropped; overflow = 1.
  - Then out_ready=1 drains exactly the 4 bytes in order.
- **Full FIFO with simultaneous pop.** FIFO full, out_ready=1 in the same cycle a byte is pushed. Required: byte accepted, count stays 4, overflow stays 0.
- **Stop with odd nibble.** run drops after 3 post-warm-up codes 0x1, 0x2, 0x5. Required:
  - Bytes 0x21 then 0x05 presented; pdm_clk = 0 and cmp_enable = 0 the next cycle.
  - busy = 0 after the FIFO empties.
- **Reset mid-run.** rst for 1 cycle with 2 bytes queued and a nibble pending. Required: next cycle out_valid=0, busy=0, pdm_clk=0, overflow=0; the restarted run begins a fresh warm-up.
